// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//
// Shared definitions for the bit-serial subtractor:
//   state_t    - FSM state encoding (IDLE / SHIFT / DONE)
//   cnt_width  - width of the bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
   // A one-bit floor keeps the declaration legal for degenerate widths.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_fullsubtractor.sv
// -----------------------------------------------------------------------------
// fullsubtractor
//
// One-bit full subtractor computing x - y - bin.
//
// Ports:
//   x    in  minuend bit
//   y    in  subtrahend bit
//   bin  in  borrow in from the less significant bit
//   d    out difference bit
//   bout out borrow out to the more significant bit
// -----------------------------------------------------------------------------
module fullsubtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d = x ^ y ^ bin;

   // Borrow when y exceeds x outright, or when they are equal and a borrow
   // is already pending from below.
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : fullsubtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial subtractor producing a - b modulo 2^WIDTH, one bit per clock,
// LSB first. A start in IDLE captures the operands; WIDTH SHIFT cycles follow,
// then a single DONE cycle announces the result. Results are held in output
// registers until the next operation completes.
//
// Parameters:
//   WIDTH   operand / result width in bits (2..32)
//
// Ports:
//   clk     in  clock, rising edge active
//   rst_n   in  asynchronous active-low reset
//   start   in  begin a subtraction (sampled in IDLE only)
//   a       in  minuend, captured on the accepting edge
//   b       in  subtrahend, captured on the accepting edge
//   busy    out high while the operation is shifting
//   done    out one-cycle pulse, result valid
//   diff    out a - b modulo 2^WIDTH
//   bout    out unsigned borrow out (a < b)
//   ovf     out two's-complement overflow of a - b
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sr;       // minuend, shifted right each SHIFT cycle
   logic [WIDTH-1:0] b_sr;       // subtrahend, shifted right each SHIFT cycle
   logic [WIDTH-2:0] res_sr;     // result bits gathered so far, MSB-aligned
   logic [WIDTH-1:0] res_cat;    // res_sr with the current bit prepended
   logic [CW-1:0]    cnt;        // index of the bit being computed
   logic             br;         // running borrow

   logic             x;
   logic             y;
   logic             d_bit;
   logic             br_next;
   logic             last_bit;

   assign x        = a_sr[0];
   assign y        = b_sr[0];
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // New bit enters at the MSB end; after the final bit this is the aligned
   // difference.
   assign res_cat  = {d_bit, res_sr};

   fullsubtractor u_fs (
      .x    (x),
      .y    (y),
      .bin  (br),
      .d    (d_bit),
      .bout (br_next)
   );

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and status outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
            end
         end

         SHIFT: begin
            busy = 1'b1;
            if (last_bit) begin
               state_next = DONE;
            end
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath: operand capture, serial subtraction and result registers
   // ---------------------------------------------------------------------------
   // NOTE: the operand, result and counter registers are cleared by reset too,
   // so an aborted operation leaves no stale data visible anywhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  cnt    <= '0;
                  br     <= 1'b0;
               end
            end

            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_cat[WIDTH-1:1];
               br     <= br_next;

               if (last_bit) begin
                  // Counter parks at WIDTH-1 instead of wrapping; the next
                  // accepting edge clears it.
                  diff <= res_cat;
                  bout <= br_next;
                  // On the last bit x and y are the captured operand MSBs and
                  // d_bit is the result MSB: overflow when the operand signs
                  // differ and the result sign differs from the minuend's.
                  ovf  <= (x != y) && (d_bit != x);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: begin
               // DONE: outputs hold, nothing to update.
            end
         endcase
      end
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor with a 4-bit and a 16-bit instance.
// Expected results come from plain integer arithmetic in ref_sub().
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   logic        clk;
   logic        rst_n;

   logic        start4;
   logic [3:0]  a4, b4;
   logic        busy4, done4, bout4, ovf4;
   logic [3:0]  diff4;

   logic        start16;
   logic [15:0] a16, b16;
   logic        busy16, done16, bout16, ovf16;
   logic [15:0] diff16;

   int          n_checks = 0;
   int          n_errors = 0;

   // Last completed result of the 4-bit instance; outputs must hold it.
   logic [63:0] prev_d4 = '0;
   logic        prev_b4 = 1'b0;
   logic        prev_o4 = 1'b0;

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .busy  (busy4),
      .done  (done4),
      .diff  (diff4),
      .bout  (bout4),
      .ovf   (ovf4)
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start16),
      .a     (a16),
      .b     (b16),
      .busy  (busy16),
      .done  (done16),
      .diff  (diff16),
      .bout  (bout16),
      .ovf   (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: w-bit subtraction from integer arithmetic.
   function automatic void ref_sub(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   output logic [63:0] d, output logic bo, output logic ov);
      longint half = longint'(1) << (w - 1);
      longint full = half * 2;
      longint sa, sb, r;
      d  = (av - bv) & 64'(full - 1);
      bo = (av < bv);
      sa = (longint'(av) >= half) ? longint'(av) - full : longint'(av);
      sb = (longint'(bv) >= half) ? longint'(bv) - full : longint'(bv);
      r  = sa - sb;
      ov = (r < -half) || (r >= half);
   endfunction

   // Caller is at a falling edge with the 4-bit DUT idle.
   task automatic do_op4(input logic [3:0] av, input logic [3:0] bv,
                         input bit restart_pulse, input string tag);
      logic [63:0] ed;
      logic        eb, eo;
      ref_sub(4, 64'(av), 64'(bv), ed, eb, eo);
      start4 = 1'b1;
      a4     = av;
      b4     = bv;
      @(negedge clk);
      start4 = 1'b0;
      a4     = 4'($urandom);
      b4     = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
         check({tag, " busy"}, 64'(busy4), 64'd1);
         check({tag, " done early"}, 64'(done4), 64'd0);
         check({tag, " diff held"}, 64'(diff4), prev_d4);
         if (restart_pulse && i == 1) begin
            start4 = 1'b1;
            a4     = 4'hF;
            b4     = 4'h0;
         end else begin
            start4 = 1'b0;
         end
         @(negedge clk);
      end
      start4 = 1'b0;
      check({tag, " busy end"}, 64'(busy4), 64'd0);
      check({tag, " done"}, 64'(done4), 64'd1);
      check({tag, " diff"}, 64'(diff4), ed);
      check({tag, " bout"}, 64'(bout4), 64'(eb));
      check({tag, " ovf"}, 64'(ovf4), 64'(eo));
      prev_d4 = ed;
      prev_b4 = eb;
      prev_o4 = eo;
      @(negedge clk);
      check({tag, " done width"}, 64'(done4), 64'd0);
      check({tag, " idle busy"}, 64'(busy4), 64'd0);
   endtask

   // Caller is at a falling edge with the 16-bit DUT idle.
   task automatic do_op16(input logic [15:0] av, input logic [15:0] bv);
      logic [63:0] ed;
      logic        eb, eo;
      int          cyc;
      ref_sub(16, 64'(av), 64'(bv), ed, eb, eo);
      start16 = 1'b1;
      a16     = av;
      b16     = bv;
      @(negedge clk);
      start16 = 1'b0;
      a16     = 16'($urandom);
      b16     = 16'($urandom);
      cyc     = 0;
      while (!done16 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("w16 latency", 64'(cyc), 64'd16);
      check("w16 diff", 64'(diff16), ed);
      check("w16 bout", 64'(bout16), 64'(eb));
      check("w16 ovf", 64'(ovf16), 64'(eo));
      @(negedge clk);
   endtask

   initial begin
      int done_at[$];
      int guard;

      rst_n   = 1'b0;
      start4  = 1'b0;
      a4      = '0;
      b4      = '0;
      start16 = 1'b0;
      a16     = '0;
      b16     = '0;

      // Reset state
      #1;
      check("rst busy", 64'(busy4), 64'd0);
      check("rst done", 64'(done4), 64'd0);
      check("rst diff", 64'(diff4), 64'd0);
      check("rst bout", 64'(bout4), 64'd0);
      check("rst ovf", 64'(ovf4), 64'd0);
      check("rst diff16", 64'(diff16), 64'd0);
      repeat (2) @(negedge clk);

      // Scenario 1: start is presented on the very edge reset is released
      rst_n = 1'b1;
      do_op4(4'b0111, 4'b0011, 1'b0, "s1");
      check("s1 diff literal", 64'(diff4), 64'b0100);

      // Scenario 2: borrow out
      do_op4(4'b0011, 4'b0101, 1'b0, "s2");
      check("s2 diff literal", 64'(diff4), 64'b1110);
      check("s2 bout literal", 64'(bout4), 64'd1);

      // Scenario 3: signed overflow both directions
      do_op4(4'b1000, 4'b0001, 1'b0, "s3a");
      check("s3a ovf literal", 64'(ovf4), 64'd1);
      do_op4(4'b0111, 4'b1111, 1'b0, "s3b");
      check("s3b diff literal", 64'(diff4), 64'b1000);
      check("s3b bout literal", 64'(bout4), 64'd1);

      // Scenario 4a: start during SHIFT is ignored
      do_op4(4'b0110, 4'b0010, 1'b1, "s4");
      repeat (3) begin
         @(negedge clk);
         check("s4 no restart busy", 64'(busy4), 64'd0);
         check("s4 no restart done", 64'(done4), 64'd0);
      end

      // Scenario 4b: start held high gives done every WIDTH+2 cycles
      start4 = 1'b1;
      a4     = 4'd9;
      b4     = 4'd3;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done4) begin
            done_at.push_back(c);
            check("s4 held diff", 64'(diff4), 64'd6);
         end
      end
      start4 = 1'b0;
      check("s4 held pulses", 64'(done_at.size()), 64'd5);
      if (done_at.size() >= 3) begin
         check("s4 first done", 64'(done_at[0]), 64'd4);
         check("s4 period 1", 64'(done_at[1] - done_at[0]), 64'd6);
         check("s4 period 2", 64'(done_at[2] - done_at[1]), 64'd6);
      end
      guard = 0;
      while ((busy4 || done4) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("s4 drain", 64'(busy4 | done4), 64'd0);
      prev_d4 = 64'd6;
      prev_b4 = 1'b0;
      prev_o4 = 1'b0;

      // Leave a nonzero result so the asynchronous clear is observable
      do_op4(4'b0111, 4'b1111, 1'b0, "s5 pre");

      // Scenario 5: reset mid-operation
      start4 = 1'b1;
      a4     = 4'b1100;
      b4     = 4'b0011;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("s5 async busy", 64'(busy4), 64'd0);
      check("s5 async done", 64'(done4), 64'd0);
      check("s5 async diff", 64'(diff4), 64'd0);
      check("s5 async bout", 64'(bout4), 64'd0);
      check("s5 async ovf", 64'(ovf4), 64'd0);
      prev_d4 = '0;
      prev_b4 = 1'b0;
      prev_o4 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("s5 no done", 64'(done4), 64'd0);
      end
      rst_n = 1'b1;
      do_op4(4'b0101, 4'b0101, 1'b0, "s5 post");
      check("s5 post diff literal", 64'(diff4), 64'd0);

      // Scenario 6: exhaustive 4-bit
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            do_op4(4'(i), 4'(j), 1'b0, "ex4");
         end
      end

      // Scenario 6: random 16-bit, plus corner operands
      do_op16(16'h8000, 16'h0001);
      do_op16(16'h7FFF, 16'hFFFF);
      do_op16(16'h0000, 16'hFFFF);
      for (int k = 0; k < 1000; k++) begin
         do_op16(16'($urandom), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_serial_subtractor

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend; captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend; captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a subtraction is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking the result as valid.
REQ-009 The block SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-010 The block SHALL have port bout, output, 1 bit: unsigned borrow-out (1 when a < b unsigned).
REQ-011 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of a - b.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 Transitions SHALL be: IDLE->SHIFT on an edge with start=1; SHIFT->DONE on the edge completing bit WIDTH-1; DONE->IDLE unconditionally after one cycle.
REQ-014 On the accepting edge (E0), a and b SHALL be loaded into internal shift registers, the bit counter cleared to 0 and the borrow flop cleared to 0.
REQ-015 Each SHIFT cycle SHALL compute one result bit LSB-first: d = x^y^br, br_next = (~x&y) | (~(x^y)&br), where x and y are the current operand LSBs.
REQ-016 Result bits SHALL shift into the diff register from the MSB end, so that diff holds the aligned result after bit WIDTH-1.
REQ-017 The block SHALL spend exactly WIDTH cycles in SHIFT.
REQ-018 busy SHALL be 1 from E0 through edge E_WIDTH, and 0 otherwise.
REQ-019 done SHALL be 1 for exactly the one cycle following E_WIDTH, while the FSM is in DONE.
REQ-020 diff, bout and ovf SHALL update only at E_WIDTH and SHALL hold their values until the next E_WIDTH or reset.
REQ-021 bout SHALL equal the final borrow flop value.
REQ-022 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), computed from the captured operands.
REQ-023 start SHALL be ignored in SHIFT and DONE; no operand capture and no restart occur in those states.
REQ-024 A start held continuously high SHALL begin a new operation on the first edge after the FSM returns to IDLE.
REQ-025 a and b SHALL be don't-care except on the accepting edge; changing them mid-operation SHALL NOT affect the result.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, and clear the counter, borrow flop and operand registers.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start accepted after deassertion SHALL produce a correct result.
REQ-029 The block SHALL accept start on the first rising edge at which rst_n is sampled high.

Structure
REQ-030 The FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL reside in a shared package/header; WIDTH stays a module parameter.
REQ-031 The per-bit difference/borrow logic SHALL be a sub-module named fullsubtractor (inputs x, y, bin; outputs d, bout), instantiated once.

Verification
REQ-032 Scenario 1, unsigned subtraction: WIDTH=4, a=0111, b=0011, start pulse -> busy for 4 cycles, done pulse one cycle after busy falls, diff=0100, bout=0, ovf=0.
REQ-033 Scenario 2, borrow-out: a=0011, b=0101 -> diff=1110, bout=1, ovf=0.
REQ-034 Scenario 3, signed overflow: a=1000, b=0001 -> diff=0111, bout=0, ovf=1; then a=0111, b=1111 -> diff=1000, bout=1, ovf=1.
REQ-035 Scenario 4, start ignored while busy: start pulsed again at the 2nd SHIFT cycle with a=1111, b=0000 -> exactly one done pulse, result is that of the first operands; start held high -> back-to-back operations with done every WIDTH+2 cycles.
REQ-036 Scenario 5, reset mid-operation: rst_n pulled low asynchronously in SHIFT -> all outputs 0 at once and no done pulse; then a=0101, b=0101 -> diff=0000, bout=0, ovf=0.
REQ-037 Scenario 6, exhaustive check: all 256 (a, b) pairs for WIDTH=4, plus 1000 random pairs for WIDTH=16 -> diff, bout and ovf match the reference arithmetic.
